// File: rtl/xalu_muldiv_pkg.sv
// xalu_muldiv_pkg: shared definitions for the xalu_muldiv register block.
//   - register offsets relative to BASE_ADDR
//   - STATUS bit positions
//   - CTRL opcode encodings
//   - iterative-core FSM state encoding
package xalu_muldiv_pkg;

    localparam logic [7:0] OFF_A0     = 8'd0;
    localparam logic [7:0] OFF_A1     = 8'd1;
    localparam logic [7:0] OFF_SHR    = 8'd2;
    localparam logic [7:0] OFF_SHL    = 8'd3;
    localparam logic [7:0] OFF_AND    = 8'd4;
    localparam logic [7:0] OFF_OR     = 8'd5;
    localparam logic [7:0] OFF_XOR    = 8'd6;
    localparam logic [7:0] OFF_NOT    = 8'd7;
    localparam logic [7:0] OFF_CTRL   = 8'd8;
    localparam logic [7:0] OFF_STATUS = 8'd9;
    localparam logic [7:0] OFF_RES_LO = 8'd10;
    localparam logic [7:0] OFF_RES_HI = 8'd11;
    localparam logic [7:0] NUM_REGS   = 8'd12;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_DZ   = 2;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/xalu_muldiv_core.sv
// xalu_muldiv_core: iterative unsigned multiply / divide, one bit per cycle.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : accepted only while idle; latches op, a, b
//   op          : 0 = shift-add MUL, 1 = restoring DIV
//   a, b        : operands
//   busy        : high while iterating
//   done, dz    : sticky completion / divide-by-zero flags, cleared by start
//   lo, hi      : MUL product halves or DIV quotient / remainder
module xalu_muldiv_core
    import xalu_muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic                  dz,
    output logic [DATA_WIDTH-1:0] lo,
    output logic [DATA_WIDTH-1:0] hi
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] count;
    logic             op_q;
    logic [W-1:0]     b_q;
    // MUL: {work_hi, work_lo} is the partial product with the unused multiplier
    // bits in the low half. DIV: work_hi is the remainder, work_lo shifts the
    // dividend out at the top and the quotient in at the bottom.
    logic [W-1:0]     work_hi;
    logic [W-1:0]     work_lo;
    logic [W-1:0]     next_hi;
    logic [W-1:0]     next_lo;
    logic [W-1:0]     mul_add;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;

    assign busy = (state == StRun);

    always_comb begin
        mul_add   = work_lo[0] ? b_q : '0;
        mul_sum   = {1'b0, work_hi} + {1'b0, mul_add};
        div_shift = {work_hi, work_lo[W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        next_hi   = work_hi;
        next_lo   = work_lo;
        if (op_q == OP_MUL) begin
            next_hi = mul_sum[W:1];
            next_lo = {mul_sum[0], work_lo[W-1:1]};
        end else if (div_shift >= {1'b0, b_q}) begin
            next_hi = div_diff[W-1:0];
            next_lo = {work_lo[W-2:0], 1'b1};
        end else begin
            next_hi = div_shift[W-1:0];
            next_lo = {work_lo[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            count   <= '0;
            op_q    <= OP_MUL;
            b_q     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            done    <= 1'b0;
            dz      <= 1'b0;
            lo      <= '0;
            hi      <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        b_q     <= b;
                        work_hi <= '0;
                        work_lo <= a;
                        count   <= '0;
                        done    <= 1'b0;
                        dz      <= 1'b0;
                        state   <= StRun;
                    end
                end
                StRun: begin
                    if (op_q == OP_DIV && b_q == '0) begin
                        // work_lo still holds the latched dividend here
                        lo    <= '1;
                        hi    <= work_lo;
                        done  <= 1'b1;
                        dz    <= 1'b1;
                        state <= StIdle;
                    end else begin
                        work_hi <= next_hi;
                        work_lo <= next_lo;
                        count   <= count + CNT_W'(1);
                        if (count == LAST) begin
                            lo    <= next_lo;
                            hi    <= next_hi;
                            done  <= 1'b1;
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/xalu_muldiv.sv
// xalu_muldiv: 12-entry register window with combinational shift/logic results
// and an iterative MUL/DIV unit.
//   clk, rst  : clock, asynchronous active-high reset
//   addr      : register address (window starts at BASE_ADDR)
//   write_en  : write strobe, sampled on rising clk
//   din       : write data
//   dout      : combinational read data for addr
module xalu_muldiv
    import xalu_muldiv_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h0F,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            addr,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int unsigned SH_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] a0;
    logic [DATA_WIDTH-1:0] a1;
    logic [7:0]            offset;
    logic                  in_win;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  dz;
    logic [DATA_WIDTH-1:0] res_lo;
    logic [DATA_WIDTH-1:0] res_hi;
    logic [SH_W-1:0]       shamt;

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
    assign offset = addr - BASE_ADDR;
    assign in_win = (offset < NUM_REGS);
    assign start  = write_en && in_win && (offset == OFF_CTRL) && !busy;
    assign shamt  = a1[SH_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0 <= '0;
            a1 <= '0;
        end else if (write_en && in_win) begin
            if (offset == OFF_A0) a0 <= din;
            if (offset == OFF_A1) a1 <= din;
        end
    end

    xalu_muldiv_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (din[0]),
        .a     (a0),
        .b     (a1),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .lo    (res_lo),
        .hi    (res_hi)
    );

    always_comb begin
        dout = '0;
        if (in_win) begin
            case (offset)
                OFF_A0:     dout = a0;
                OFF_A1:     dout = a1;
                OFF_SHR:    dout = a0 >> shamt;
                OFF_SHL:    dout = a0 << shamt;
                OFF_AND:    dout = a0 & a1;
                OFF_OR:     dout = a0 | a1;
                OFF_XOR:    dout = a0 ^ a1;
                OFF_NOT:    dout = ~a0;
                OFF_STATUS: begin
                    dout[STAT_BUSY] = busy;
                    dout[STAT_DONE] = done;
                    dout[STAT_DZ]   = dz;
                end
                OFF_RES_LO: dout = res_lo;
                OFF_RES_HI: dout = res_hi;
                default:    dout = '0;
            endcase
        end
    end

endmodule
